// File: rtl/ysyx_icache.sv
// ysyx_icache: direct-mapped, flop-based instruction cache with word-serial bus refill.
//
// Ports:
//    clk, rst                     clock, asynchronous active-high reset
//    ifu_araddr, ifu_arvalid      fetch request (held by the IFU until ifu_rvalid_o)
//    ifu_rdata_o, ifu_rvalid_o    fetch response; a hit answers in the same cycle
//    fence_i                      one-cycle pulse that invalidates every line
//    bus_araddr_o, bus_arvalid_o  refill word request towards the bus arbiter
//    bus_rdata, bus_rvalid        refill word response from the bus arbiter
//    hit_cnt_o, miss_cnt_o        performance counters
//
// Build option: define YSYX_ICACHE_PERF_EN to implement the hit/miss counters;
// when it is undefined both counter outputs are tied to zero.
module ysyx_icache #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SET_N      = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ifu_araddr,
   input  logic              ifu_arvalid,
   output logic [DATA_W-1:0] ifu_rdata_o,
   output logic              ifu_rvalid_o,
   input  logic              fence_i,
   output logic [ADDR_W-1:0] bus_araddr_o,
   output logic              bus_arvalid_o,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_rvalid,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
);
   localparam int WI = $clog2(LINE_WORDS);
   localparam int SI = $clog2(SET_N);
   localparam int TW = ADDR_W - SI - WI - 2;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t              r_state, w_next;
   logic [SET_N-1:0]    r_valid;
   logic [TW-1:0]       r_tag_mem  [SET_N];
   logic [DATA_W-1:0]   r_data_mem [SET_N][LINE_WORDS];
   logic [TW-1:0]       r_tag;
   logic [SI-1:0]       r_set;
   logic [WI-1:0]       r_cnt;
   logic                r_gap;
   logic                r_fence;
   logic [TW-1:0]       w_tag;
   logic [SI-1:0]       w_set;
   logic [WI-1:0]       w_word;
   logic                w_hit, w_miss, w_beat, w_last;
   logic                w_unused;

   assign w_word   = ifu_araddr[WI+1:2];
   assign w_set    = ifu_araddr[SI+WI+1:WI+2];
   assign w_tag    = ifu_araddr[ADDR_W-1:SI+WI+2];
   assign w_unused = &{1'b0, ifu_araddr[1:0]};

   assign w_hit  = (r_state == IDLE) && ifu_arvalid && r_valid[w_set] && (r_tag_mem[w_set] == w_tag);
   assign w_miss = (r_state == IDLE) && ifu_arvalid && !w_hit;
   assign w_beat = bus_arvalid_o && bus_rvalid;
   assign w_last = w_beat && (r_cnt == WI'(LINE_WORDS - 1));

   assign ifu_rvalid_o = w_hit;
   assign ifu_rdata_o  = w_hit ? r_data_mem[w_set][w_word] : '0;
   assign bus_araddr_o = bus_arvalid_o ? {r_tag, r_set, r_cnt, 2'b00} : '0;

   // r_gap is the mandatory idle cycle on the bus after every accepted beat.
   always_comb begin
      w_next        = (r_state == IDLE) ? (w_miss ? REFILL : IDLE) : (w_last ? IDLE : REFILL);
      bus_arvalid_o = (r_state == REFILL) && !r_gap;
   end

   // A fence seen during refill is deferred to the first IDLE cycle, so the held
   // request still hits on the freshly filled line before everything is invalidated.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_valid <= '0;
         r_cnt   <= '0;
         r_gap   <= 1'b0;
         r_fence <= 1'b0;
      end else begin
         r_state <= w_next;
         r_gap   <= w_beat;
         r_cnt   <= w_miss ? '0 : w_beat ? r_cnt + WI'(1) : r_cnt;
         r_fence <= (r_state == IDLE) ? 1'b0 : (r_fence || fence_i);
         if ((r_state == IDLE) && (fence_i || r_fence))
            r_valid <= '0;
         else if (w_miss)
            r_valid[w_set] <= 1'b0;
         else if (w_last)
            r_valid[r_set] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_miss) begin
         r_tag <= w_tag;
         r_set <= w_set;
      end
      if (w_beat)
         r_data_mem[r_set][r_cnt] <= bus_rdata;
      if (w_last)
         r_tag_mem[r_set] <= r_tag;
   end

`ifdef YSYX_ICACHE_PERF_EN
   logic [31:0] r_hit_cnt, r_miss_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         r_hit_cnt  <= r_hit_cnt + 32'(w_hit);
         r_miss_cnt <= r_miss_cnt + 32'(w_miss);
      end
   end

   assign hit_cnt_o  = r_hit_cnt;
   assign miss_cnt_o = r_miss_cnt;
`else
   assign hit_cnt_o  = '0;
   assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ysyx_icache.sv
// tb_ysyx_icache: directed table plus randomized fetches against a set/tag reference model.
module tb_ysyx_icache;
   localparam int SET_N = 16;
   localparam int LW    = 4;
   localparam int WB    = $clog2(LW) + 2;
   localparam int SB    = $clog2(SET_N);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ifu_araddr = '0;
   logic        ifu_arvalid = 1'b0;
   logic [31:0] ifu_rdata_o;
   logic        ifu_rvalid_o;
   logic        fence_i = 1'b0;
   logic [31:0] bus_araddr_o;
   logic        bus_arvalid_o;
   logic [31:0] bus_rdata = '0;
   logic        bus_rvalid = 1'b0;
   logic [31:0] hit_cnt_o, miss_cnt_o;

   ysyx_icache #(.ADDR_W(32), .DATA_W(32), .SET_N(SET_N), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
      .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o),
      .fence_i(fence_i),
      .bus_araddr_o(bus_araddr_o), .bus_arvalid_o(bus_arvalid_o),
      .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
      .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] bq[$];
   int          rv_cnt = 0;

   bit          mv[SET_N];
   logic [31:0] mt[SET_N];
   int unsigned m_hit = 0, m_miss = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a[31:4] == 28'h8000000) return 32'h11 * (32'(a[3:2]) + 32'd1);
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   function automatic int m_set(input logic [31:0] a);
      return int'((a >> WB) % SET_N);
   endfunction

   function automatic logic [31:0] m_tag(input logic [31:0] a);
      return a >> (WB + SB);
   endfunction

   function automatic bit m_lookup(input logic [31:0] a);
      return mv[m_set(a)] && (mt[m_set(a)] == m_tag(a));
   endfunction

   function automatic void m_clear();
      foreach (mv[i]) mv[i] = 1'b0;
   endfunction

   function automatic void m_reset();
      m_clear();
      m_hit = 0;
      m_miss = 0;
   endfunction

   // One fetch as seen by the model: a fence arriving with the fetch applies after the
   // lookup, a fence during refill applies after delivery; every fetch ends in one hit.
   function automatic void m_access(input logic [31:0] a, input bit fw, input bit fm);
      bit h = m_lookup(a);
      if (fw) m_clear();
      if (!h) begin
         m_miss++;
         mv[m_set(a)] = 1'b1;
         mt[m_set(a)] = m_tag(a);
      end
      m_hit++;
      if (fm) m_clear();
   endfunction

   function automatic logic [31:0] exp_hit_cnt();
`ifdef YSYX_ICACHE_PERF_EN
      return m_hit;
`else
      return 0;
`endif
   endfunction

   function automatic logic [31:0] exp_miss_cnt();
`ifdef YSYX_ICACHE_PERF_EN
      return m_miss;
`else
      return 0;
`endif
   endfunction

   // Bus arbiter model: accepts a request, answers one cycle later for one cycle.
   always @(posedge clk) begin
      if (rst) bus_rvalid <= 1'b0;
      else if (bus_rvalid) bus_rvalid <= 1'b0;
      else if (bus_arvalid_o) begin
         bus_rvalid <= 1'b1;
         bus_rdata  <= mem(bus_araddr_o);
         rv_cnt     <= rv_cnt + 1;
         bq.push_back(bus_araddr_o);
      end
   end

   logic        p_av = 1'b0, p_beat = 1'b0, p_rst = 1'b1;
   logic [31:0] p_addr = '0;

   always @(negedge clk) begin
      if (!rst && !p_rst) begin
         if (!ifu_rvalid_o) chk("rdata_zero_when_idle", ifu_rdata_o, 0);
         if (p_beat) chk("bus_gap_after_beat", bus_arvalid_o, 0);
         else if (p_av) chk("bus_req_held", {bus_arvalid_o, bus_araddr_o}, {1'b1, p_addr});
      end
      p_av   <= bus_arvalid_o;
      p_beat <= bus_arvalid_o && bus_rvalid;
      p_addr <= bus_araddr_o;
      p_rst  <= rst;
   end

   task automatic fetch(input logic [31:0] a, input bit fw, output logic [31:0] d,
                        output int lat, output bit ok);
      ifu_araddr = a;
      ifu_arvalid = 1'b1;
      fence_i = fw;
      ok = 1'b0;
      d = '0;
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ifu_rvalid_o && !ok) begin
            d = ifu_rdata_o;
            lat = i;
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
         if (fw && i == 0) fence_i = 1'b0;
         if (ok) break;
      end
      ifu_arvalid = 1'b0;
   endtask

   task automatic on_beat(input int n, input bit do_rst);
      int b0 = rv_cnt;
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (bus_rvalid && rv_cnt == b0 + n) begin
            seen = 1'b1;
            if (do_rst) begin
               rst = 1'b1;
               bq.delete();
               #1;
               chk("rst_bus_arvalid", bus_arvalid_o, 0);
               chk("rst_bus_araddr", bus_araddr_o, 0);
               chk("rst_ifu_rvalid", ifu_rvalid_o, 0);
               chk("rst_hit_cnt", hit_cnt_o, 0);
               chk("rst_miss_cnt", miss_cnt_o, 0);
               @(posedge clk);
               #1;
               rst = 1'b0;
               m_reset();
            end else begin
               fence_i = 1'b1;
               @(posedge clk);
               #1;
               fence_i = 1'b0;
            end
         end
      end
      chk("beat_wait", seen, 1);
   endtask

   task automatic check_bus(input logic [31:0] a, input bit eh);
      logic [31:0] base = a & ~32'(LW * 4 - 1);
      chk("bus_req_count", bq.size(), eh ? 0 : LW);
      if (!eh && bq.size() == LW)
         foreach (bq[i]) chk("bus_addr", bq[i], base + 32'(4 * i));
   endtask

   task automatic do_fetch(input logic [31:0] a, input bit fw, input bit fm,
                           input bit eh, input logic [31:0] ed);
      logic [31:0] d;
      int lat;
      bit ok;
      bq.delete();
      fork
         fetch(a, fw, d, lat, ok);
         if (fm) on_beat(2, 1'b0);
      join
      m_access(a, fw, fm);
      chk("fetch_done", ok, 1);
      chk("latency", lat, eh ? 0 : 3 * LW);
      chk("rdata", d, ed);
      check_bus(a, eh);
      chk("hit_cnt", hit_cnt_o, exp_hit_cnt());
      chk("miss_cnt", miss_cnt_o, exp_miss_cnt());
   endtask

   typedef struct {
      logic [31:0] addr;
      bit          fw;
      bit          fm;
      bit          eh;
      logic [31:0] ed;
   } vec_t;

   initial begin
      vec_t vt[$];
      logic [31:0] d, a;
      int lat;
      bit ok, fw, fm, eh;

      vt.push_back('{32'h80000000, 0, 0, 0, 32'h11});
      vt.push_back('{32'h80000008, 0, 0, 1, 32'h33});
      vt.push_back('{32'h8000000C, 0, 0, 1, 32'h44});
      vt.push_back('{32'h80000100, 0, 0, 0, mem(32'h80000100)});
      vt.push_back('{32'h80000000, 0, 0, 0, 32'h11});
      vt.push_back('{32'h80000010, 0, 1, 0, mem(32'h80000010)});
      vt.push_back('{32'h80000010, 0, 0, 0, mem(32'h80000010)});
      vt.push_back('{32'h80000000, 0, 0, 0, 32'h11});
      vt.push_back('{32'h80000004, 1, 0, 1, 32'h22});
      vt.push_back('{32'h80000004, 0, 0, 0, 32'h22});

      m_reset();
      #2;
      chk("reset_ifu_rvalid", ifu_rvalid_o, 0);
      chk("reset_ifu_rdata", ifu_rdata_o, 0);
      chk("reset_bus_arvalid", bus_arvalid_o, 0);
      chk("reset_bus_araddr", bus_araddr_o, 0);
      chk("reset_hit_cnt", hit_cnt_o, 0);
      chk("reset_miss_cnt", miss_cnt_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vt[i]) do_fetch(vt[i].addr, vt[i].fw, vt[i].fm, vt[i].eh, vt[i].ed);

      a = 32'h80000020;
      bq.delete();
      fork
         fetch(a, 1'b0, d, lat, ok);
         on_beat(3, 1'b1);
      join
      m_access(a, 1'b0, 1'b0);
      chk("rst_refetch_done", ok, 1);
      chk("rst_refetch_rdata", d, mem(a));
      check_bus(a, 1'b0);
      chk("rst_hit_cnt_after", hit_cnt_o, exp_hit_cnt());
      chk("rst_miss_cnt_after", miss_cnt_o, exp_miss_cnt());
      do_fetch(a, 1'b0, 1'b0, 1'b1, mem(a));

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            fence_i = 1'b1;
            @(posedge clk);
            #1;
            fence_i = 1'b0;
            m_clear();
         end
         a  = 32'h80000000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
         eh = m_lookup(a);
         fw = ($urandom_range(0, 9) == 0);
         fm = !eh && ($urandom_range(0, 5) == 0);
         do_fetch(a, fw, fm, eh, mem(a));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_icache.md
YSYX_ICACHE -- requirements
Module: ysyx_icache

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter SET_N, default 16, number of sets in the direct-mapped cache, power of two.
REQ-004 Parameter LINE_WORDS, default 4, words per line, power of two.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ifu_araddr  in  ADDR_W  fetch address, word-aligned.
REQ-008 ifu_arvalid  in  1  fetch request.
REQ-009 ifu_rdata_o  out  DATA_W  fetched instruction.
REQ-010 ifu_rvalid_o  out  1  fetch response valid.
REQ-011 fence_i  in  1  single-cycle pulse requesting invalidation of all lines.
REQ-012 bus_araddr_o  out  ADDR_W  refill word address, to the bus arbiter's ifu_araddr.
REQ-013 bus_arvalid_o  out  1  refill request, to the arbiter's ifu_arvalid.
REQ-014 bus_rdata  in  DATA_W  refill data, from the arbiter's ifu_rdata_o.
REQ-015 bus_rvalid  in  1  refill data valid, from the arbiter's ifu_rvalid_o.
REQ-016 hit_cnt_o  out  32  hit counter.
REQ-017 miss_cnt_o  out  32  miss counter.

Function
REQ-018 Address split: offset[1:0] ignored; word index = log2(LINE_WORDS) bits; set index = log2(SET_N) bits; tag = remaining upper bits.
REQ-019 Storage: per set one valid bit, one tag, LINE_WORDS data words, all in flops.
REQ-020 States: IDLE, REFILL.
REQ-021 IDLE, ifu_arvalid, valid && tag match (hit): ifu_rvalid_o=1 and ifu_rdata_o=selected word combinationally in the same cycle; zero-cycle hit latency.
REQ-022 IDLE, ifu_arvalid, miss: ifu_rvalid_o=0; next edge latch tag/set, clear word counter cnt, clear the set's valid bit, go to REFILL.
REQ-023 REFILL: bus_arvalid_o=1; bus_araddr_o={latched tag, set, cnt, 2'b00}; held stable until bus_rvalid.
REQ-024 REFILL, bus_rvalid: write bus_rdata to word cnt, cnt+1; bus_arvalid_o drops for exactly one cycle after each beat before the next word is requested.
REQ-025 REFILL, bus_rvalid with cnt==LINE_WORDS-1: write tag, set valid, go to IDLE; the held request hits in the following cycle.
REQ-026 Miss penalty with a 1-cycle bus: request at cycle 0 gets rvalid no earlier than cycle 1+2*LINE_WORDS.
REQ-027 IFU SHALL hold ifu_araddr/ifu_arvalid stable until ifu_rvalid_o; if ifu_arvalid drops mid-refill the refill still completes, no abort.
REQ-028 ifu_rvalid_o=0 and bus_arvalid_o is the only bus activity while in REFILL.
REQ-029 bus_arvalid_o=0 in IDLE; ifu_rdata_o=0 whenever ifu_rvalid_o=0.
REQ-030 fence_i in IDLE: all valid bits cleared at next edge; a fetch in that same cycle reports its hit/miss against pre-clear state.
REQ-031 fence_i in REFILL: set pending flag; on refill completion clear all valid bits, including the just-filled line, then return to IDLE.
REQ-032 Counters count once per resolved request: hit_cnt_o +1 on each hit cycle, miss_cnt_o +1 on each IDLE->REFILL transition; wrap modulo 2^32.

Reset
REQ-033 rst asserted: state=IDLE, all valid bits=0, cnt=0, fence pending=0, counters=0, all outputs 0, effective immediately without clock.
REQ-034 rst mid-refill: partial line discarded, set left invalid, bus_arvalid_o deasserted asynchronously.
REQ-035 Tag and data flops need no reset.

Configuration
REQ-036 Macro YSYX_ICACHE_PERF_EN defined: hit/miss counters implemented per REQ-032.
REQ-037 Macro undefined: no counter flops, hit_cnt_o and miss_cnt_o tied to 0; all other behaviour identical.

Verification
REQ-038 Cold fetch 0x80000000, bus returns 0x11,0x22,0x33,0x44 one cycle after each request -> bus addresses 0x80000000,04,08,0C in order; then ifu_rdata_o=0x11; miss_cnt_o=1.
REQ-039 After REQ-038, fetch 0x80000008 -> ifu_rvalid_o same cycle, ifu_rdata_o=0x33, no bus_arvalid_o, hit_cnt_o=2.
REQ-040 Fetch 0x80000100 (same set, different tag, SET_N=16) -> refill 0x80000100..0C; then refetch 0x80000000 -> misses again.
REQ-041 fence_i pulsed during 2nd refill beat of 0x80000010 -> refill completes, line delivered, then refetch of 0x80000010 misses.
REQ-042 rst asserted during 3rd refill beat -> bus_arvalid_o=0 before next edge; refetch of the same address issues full 4-word refill.
REQ-043 Build without YSYX_ICACHE_PERF_EN, rerun REQ-038 -> identical bus traffic and data, hit_cnt_o=miss_cnt_o=0.
